// File: rtl/bus_mailbox_pkg.sv
// Shared constants for the bus mailbox slave: register offsets and the bit
// positions inside the STATUS and CTRL registers.
package bus_mailbox_pkg;

  localparam logic [2:0] OFS_DATA   = 3'h0;
  localparam logic [2:0] OFS_STATUS = 3'h1;
  localparam logic [2:0] OFS_CTRL   = 3'h2;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_UDF     = 3;
  localparam int ST_CNT_LSB = 8;

  localparam int CTL_IRQ_EN = 0;
  localparam int CTL_FLUSH  = 1;

endpackage

// File: rtl/mailbox_fifo.sv
// Power-of-two circular FIFO of 32-bit words with flush, used as the mailbox
// storage; full pushes and empty pops leave the state untouched.
module mailbox_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_empty_next
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;
  logic [CNT_W-1:0] w_count_next;

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_do_push = i_push & ~o_full & ~i_flush;
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

  always_comb begin
    w_count_next = r_count;
    if (i_flush)
      w_count_next = '0;
    else if (w_do_push)
      w_count_next = r_count + 1'b1;
    else if (w_do_pop)
      w_count_next = r_count - 1'b1;
  end

  assign o_empty_next = (w_count_next == '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_count <= w_count_next;
      if (i_flush)
        r_rd_ptr <= r_wr_ptr;
      else if (w_do_push)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      else if (w_do_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push)
      r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/bus_mailbox_slave.sv
// Register-mapped mailbox on one shared-bus slave slot: DATA push/pop, STATUS
// with sticky error flags, CTRL with interrupt enable and flush.
module bus_mailbox_slave
  import bus_mailbox_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_sel,
  input  logic        s_wr,
  input  logic [7:0]  s_address,
  input  logic [31:0] s_din,
  output logic [31:0] s_dout,
  output logic        irq
);

  logic [2:0]       w_ofs;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_push;
  logic             w_pop;
  logic             w_flush;
  logic             w_ctrl_wr;
  logic             w_stat_wr;
  logic             w_irq_en_next;
  logic [31:0]      w_rdata;
  logic [CNT_W-1:0] w_count;
  logic             w_empty;
  logic             w_full;
  logic             w_empty_next;
  logic             w_unused_addr;

  logic r_overflow;
  logic r_underflow;
  logic r_irq_en;
  logic r_irq;

  assign w_ofs         = s_address[2:0];
  assign w_unused_addr = &{1'b0, s_address[7:3]};

  assign w_wr_acc  = s_sel & s_wr;
  assign w_rd_acc  = s_sel & ~s_wr;
  assign w_push    = w_wr_acc & (w_ofs == OFS_DATA);
  assign w_pop     = w_rd_acc & (w_ofs == OFS_DATA);
  assign w_ctrl_wr = w_wr_acc & (w_ofs == OFS_CTRL);
  assign w_stat_wr = w_wr_acc & (w_ofs == OFS_STATUS);
  assign w_flush   = w_ctrl_wr & s_din[CTL_FLUSH];

  assign w_irq_en_next = w_ctrl_wr ? s_din[CTL_IRQ_EN] : r_irq_en;

  mailbox_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_flush      (w_flush),
    .i_wdata      (s_din),
    .o_rdata      (w_rdata),
    .o_count      (w_count),
    .o_empty      (w_empty),
    .o_full       (w_full),
    .o_empty_next (w_empty_next)
  );

  // A new error event on the same edge as a write-1 clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_irq_en    <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_overflow  <= (w_push & w_full) |
                     (r_overflow & ~(w_stat_wr & s_din[ST_OVF]));
      r_underflow <= (w_pop & w_empty) |
                     (r_underflow & ~(w_stat_wr & s_din[ST_UDF]));
      r_irq_en    <= w_irq_en_next;
      r_irq       <= w_irq_en_next & ~w_empty_next;
    end
  end

  assign irq = r_irq;

  always_comb begin
    s_dout = '0;
    if (w_rd_acc) begin
      case (w_ofs)
        OFS_DATA:
          s_dout = w_empty ? 32'h0 : w_rdata;
        OFS_STATUS: begin
          s_dout[ST_EMPTY]               = w_empty;
          s_dout[ST_FULL]                = w_full;
          s_dout[ST_OVF]                 = r_overflow;
          s_dout[ST_UDF]                 = r_underflow;
          s_dout[ST_CNT_LSB +: CNT_W]    = w_count;
        end
        OFS_CTRL:
          s_dout[CTL_IRQ_EN] = r_irq_en;
        default:
          s_dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_mailbox_slave.sv
// Directed bench for bus_mailbox_slave (DEPTH=8): register map, FIFO order,
// sticky flags, interrupt timing, flush, pointer wrap and mid-run reset.
module tb_bus_mailbox_slave;

  logic        clk;
  logic        reset_n;
  logic        s_sel;
  logic        s_wr;
  logic [7:0]  s_address;
  logic [31:0] s_din;
  logic [31:0] s_dout;
  logic        irq;

  int assertCount;
  int failCount;
  logic [31:0] rd;

  bus_mailbox_slave #(.DEPTH(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_sel     (s_sel),
    .s_wr      (s_wr),
    .s_address (s_address),
    .s_din     (s_din),
    .s_dout    (s_dout),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One bus access: drive after the falling edge, sample read data mid-cycle,
  // let the rising edge commit, then release the bus.
  task automatic applyStimulus(input logic wr, input logic [7:0] addr,
                               input logic [31:0] din, output logic [31:0] dout);
    @(negedge clk);
    s_sel     = 1'b1;
    s_wr      = wr;
    s_address = addr;
    s_din     = din;
    #1;
    dout = s_dout;
    @(posedge clk);
    #1;
    s_sel = 1'b0;
    s_wr  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset_n     = 1'b0;
    s_sel       = 1'b0;
    s_wr        = 1'b0;
    s_address   = 8'h00;
    s_din       = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] reset state");
    applyStimulus(1'b0, 8'h01, 32'h0, rd);
    checkOutput("status_after_reset", rd, 32'h0000_0001);
    checkOutput("irq_after_reset", {31'b0, irq}, 32'h0);
    applyStimulus(1'b0, 8'h00, 32'h0, rd);
    applyStimulus(1'b1, 8'h01, 32'h8, rd);

    $display("[TB] basic push/pop order");
    applyStimulus(1'b1, 8'h00, 32'hA, rd);
    applyStimulus(1'b1, 8'h00, 32'hB, rd);
    applyStimulus(1'b1, 8'hF8, 32'hC, rd);
    applyStimulus(1'b0, 8'h01, 32'h0, rd);
    checkOutput("status_count3", rd, 32'h0000_0300);
    applyStimulus(1'b0, 8'h00, 32'h0, rd);
    checkOutput("pop_A", rd, 32'hA);
    applyStimulus(1'b0, 8'h00, 32'h0, rd);
    checkOutput("pop_B", rd, 32'hB);
    applyStimulus(1'b0, 8'h00, 32'h0, rd);
    checkOutput("pop_C", rd, 32'hC);
    applyStimulus(1'b0, 8'h01, 32'h0, rd);
    checkOutput("status_empty_again", rd, 32'h0000_0001);

    $display("[TB] overflow");
    for (int i = 1; i <= 9; i++)
      applyStimulus(1'b1, 8'h00, 32'(i), rd);
    applyStimulus(1'b0, 8'h01, 32'h0, rd);
    checkOutput("status_full_ovf", rd, 32'h0000_0806);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b0, 8'h00, 32'h0, rd);
      checkOutput($sformatf("pop_full_%0d", i), rd, 32'(i));
    end
    applyStimulus(1'b0, 8'h01, 32'h0, rd);
    checkOutput("status_ovf_sticky", rd, 32'h0000_0005);
    applyStimulus(1'b1, 8'h01, 32'h4, rd);
    applyStimulus(1'b0, 8'h01, 32'h0, rd);
    checkOutput("status_ovf_cleared", rd, 32'h0000_0001);

    $display("[TB] underflow");
    applyStimulus(1'b0, 8'h00, 32'h0, rd);
    checkOutput("pop_empty_data", rd, 32'h0);
    applyStimulus(1'b0, 8'h01, 32'h0, rd);
    checkOutput("status_udf", rd, 32'h0000_0009);
    applyStimulus(1'b1, 8'h01, 32'h8, rd);
    applyStimulus(1'b0, 8'h01, 32'h0, rd);
    checkOutput("status_udf_cleared", rd, 32'h0000_0001);

    $display("[TB] unmapped offsets");
    applyStimulus(1'b1, 8'h05, 32'hFFFF_FFFF, rd);
    applyStimulus(1'b0, 8'h05, 32'h0, rd);
    checkOutput("unmapped_read", rd, 32'h0);
    applyStimulus(1'b0, 8'h01, 32'h0, rd);
    checkOutput("status_after_unmapped", rd, 32'h0000_0001);

    $display("[TB] interrupt");
    applyStimulus(1'b1, 8'h02, 32'h1, rd);
    checkOutput("irq_en_no_data", {31'b0, irq}, 32'h0);
    applyStimulus(1'b1, 8'h00, 32'h55, rd);
    checkOutput("irq_after_push", {31'b0, irq}, 32'h1);
    applyStimulus(1'b0, 8'h00, 32'h0, rd);
    checkOutput("pop_55", rd, 32'h55);
    checkOutput("irq_after_pop", {31'b0, irq}, 32'h0);

    $display("[TB] flush");
    applyStimulus(1'b1, 8'h00, 32'h11, rd);
    applyStimulus(1'b1, 8'h00, 32'h22, rd);
    checkOutput("irq_before_flush", {31'b0, irq}, 32'h1);
    applyStimulus(1'b1, 8'h02, 32'h3, rd);
    checkOutput("irq_after_flush", {31'b0, irq}, 32'h0);
    applyStimulus(1'b0, 8'h01, 32'h0, rd);
    checkOutput("status_after_flush", rd, 32'h0000_0001);
    applyStimulus(1'b0, 8'h02, 32'h0, rd);
    checkOutput("ctrl_readback", rd, 32'h0000_0001);

    $display("[TB] pointer wrap");
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++)
        applyStimulus(1'b1, 8'h00, 32'h100 * r + i, rd);
      for (int i = 0; i < 5; i++) begin
        applyStimulus(1'b0, 8'h00, 32'h0, rd);
        checkOutput($sformatf("wrap_r%0d_i%0d", r, i), rd, 32'h100 * r + i);
      end
    end

    $display("[TB] reset with data queued");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 8'h00, 32'hE0 + i, rd);
    applyStimulus(1'b0, 8'h01, 32'h0, rd);
    checkOutput("status_4_queued", rd, 32'h0000_0400);
    checkOutput("irq_4_queued", {31'b0, irq}, 32'h1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("irq_in_reset", {31'b0, irq}, 32'h0);
    applyStimulus(1'b0, 8'h01, 32'h0, rd);
    checkOutput("status_in_reset", rd, 32'h0000_0001);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, 8'h02, 32'h0, rd);
    checkOutput("ctrl_after_reset", rd, 32'h0);
    applyStimulus(1'b0, 8'h00, 32'h0, rd);
    checkOutput("pop_after_reset", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
